glb_stream_sink: RTL and testbench
==================================

// Module: glb_stream_sink
// PURPOSE
//  Synthesizable downstream consumer of the 17-bit valid/ready stream that GLB-side sources push into
//  the memory-core tile. Captures cfg_tx_size words into a local buffer after a flush pulse.
//  Offers programmable back-pressure and optional stop-on-token termination. Exposes a readback port
//  so benches compare captured data against golden generic_memory_*.txt contents.
// PARAMETERS
//  DEPTH      1024  capture buffer words (power of 2)
//  DATA_W     17    stream width; bit DATA_W-1 = control-token flag, [15:0] = payload
//  CNT_W      $clog2(DEPTH)+1  width of count/tx-size fields (0..DEPTH inclusive)
// PORTS
//  clk               in   1       clock
//  rst               in   1       asynchronous reset, active-high
//  flush             in   1       re-arm; capture begins on cycle after falling edge
//  data              in   DATA_W  stream payload from upstream source
//  valid             in   1       upstream word valid
//  ready             out  1       sink accepts word this cycle (function of registers only)
//  done              out  1       capture complete, sticky until flush/rst
//  count             out  CNT_W   words accepted since last flush
//  cfg_tx_size       in   CNT_W   words to capture; values > DEPTH clamp to DEPTH
//  cfg_stall_period  in   4       0: no stall; N>0: ready high N cycles then low 1, repeating
//  cfg_stop_on_token in   1       1: a word with data[16]=1 terminates capture
//  rd_addr           in   CNT_W-1 readback address
//  rd_data           out  DATA_W  combinational mem[rd_addr]
//  err               out  1       sticky protocol error (0 unless GLB_SINK_PROTO_CHECK_EN)
// BEHAVIOUR
//  Reset: state=IDLE, ready=0, done=0, count=0, err=0, stall counter=0; memory contents undefined.
//  FSM: IDLE -flush=1-> FLUSH; FLUSH -flush falls-> CAPTURE (or DONE if clamped tx_size==0);
//    CAPTURE -last accept or stop token-> DONE; DONE holds. flush=1 in any state -> FLUSH,
//    clearing count/done/err/stall counter the same edge. Flush edge detect via registered flush.
//  ready = (state==CAPTURE) && !stall_slot && (count < tx_size_clamped). No comb path valid->ready.
//  Accept when valid&&ready at posedge: mem[count[CNT_W-2:0]] <= data; count <= count+1.
//    Word readable on rd_data the cycle after acceptance.
//  Completion: done rises the cycle after the accepting edge that makes count==tx_size, or that
//    accepts a token word with cfg_stop_on_token=1 (token is stored and counted). ready low from
//    that cycle on; a valid held afterward is ignored, never written.
//  Stall counter advances only in CAPTURE; stall_slot when counter==cfg_stall_period (period!=0);
//    wraps to 0 after the stall slot. cfg_* sampled live; change only while not CAPTURE.
//  count saturates at DEPTH; address never wraps past DEPTH-1 because of clamp.
//  rst mid-capture: immediate return to reset values; no further writes.
// CONFIGURATION
//  GLB_SINK_PROTO_CHECK_EN defined: in CAPTURE, if the previous cycle had valid=1 && ready=0
//    and this cycle valid==0 or data differs, err sets (sticky until flush/rst).
//  Undefined: no hold registers, err tied 0.
// STRUCTURE
//  glb_sink_pkg: state enum {IDLE,FLUSH,CAPTURE,DONE}, DATA_W, TOKEN_BIT=16, DEFAULT_DEPTH.
//  Sub-module glb_sink_stall_gen: stall counter + stall_slot output (inputs clk,rst,en,clr,period).
//  Top: FSM, count, capture memory array, readback mux, optional checker.
// TESTING
//  1 tx_size=8, stall=0, source streams 0..7 after flush -> ready from cycle 1 after flush fall,
//    8 accepts in 8 cycles, done 1 cycle later, rd_data[0..7]==0..7, count==8.
//  2 tx_size=6, stall=2 -> ready pattern 1,1,0,1,1,0,1,1 (hold ready low after final accept),
//    6 words stored in order, done after 9th capture cycle.
//  3 stop_on_token=1, tx_size=16, token 0x10100 as 4th word -> count==4, mem[3]==0x10100,
//    done next cycle, later valid words not written.
//  4 tx_size=0 -> done 1 cycle after flush falls, ready never high; tx_size=2000 clamps to 1024.
//  5 rst asserted after 3 accepts -> outputs at reset values same cycle; new flush restarts at addr 0.
//  6 (GLB_SINK_PROTO_CHECK_EN) source changes data while stalled -> err=1 next cycle, cleared by flush.

Source files
------------

// File: rtl/glb_sink_pkg.sv
// glb_sink_pkg
//   Shared types and constants for the GLB stream sink.
//   - DATA_W        : stream width (bit DATA_W-1 is the control-token flag)
//   - TOKEN_BIT     : index of the control-token flag
//   - DEFAULT_DEPTH : default capture buffer depth in words
//   - sink_state_e  : capture FSM state encoding
package glb_sink_pkg;

  localparam int DATA_W        = 17;
  localparam int TOKEN_BIT     = 16;
  localparam int DEFAULT_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } sink_state_e;

endpackage

// File: rtl/glb_sink_stall_gen.sv
// glb_sink_stall_gen
//   Programmable back-pressure pattern generator. With period N>0 the
//   stall_slot output is low for N enabled cycles, then high for one,
//   repeating. Period 0 never stalls.
// Ports:
//   clk        in  clock
//   rst        in  asynchronous reset, active-high
//   en         in  advance the pattern this cycle (sink is capturing)
//   clr        in  restart the pattern from the first ready slot
//   period     in  4-bit stall period (0 = no stall)
//   stall_slot out high during the stall cycle of the pattern
module glb_sink_stall_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] period,
  output logic       stall_slot
);

  logic [3:0] cnt_r;

  // Position within the stall pattern; wraps to 0 right after the stall slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (clr) begin
      cnt_r <= 4'd0;
    end else if (en) begin
      // >= also recovers cleanly if the period is lowered below the count
      if ((period == 4'd0) || (cnt_r >= period)) begin
        cnt_r <= 4'd0;
      end else begin
        cnt_r <= cnt_r + 4'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign stall_slot = (period != 4'd0) && (cnt_r == period);

endmodule

// File: rtl/glb_stream_sink.sv
// glb_stream_sink
//   Downstream consumer of the GLB valid/ready stream. After a flush pulse
//   it captures up to cfg_tx_size words (clamped to DEPTH) into a local
//   buffer, optionally stopping early on a control-token word, with a
//   programmable back-pressure pattern. A combinational readback port lets
//   the captured contents be inspected.
//   Optional feature: define GLB_SINK_PROTO_CHECK_EN to enable the sticky
//   protocol checker (source dropped or changed a word while stalled);
//   otherwise err is tied low.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               re-arm; capture starts the cycle after it falls
//   data, valid         upstream stream word and its valid
//   ready               sink accepts this cycle (registers only, no valid path)
//   done                capture complete, sticky until flush/rst
//   count               words accepted since the last flush
//   cfg_tx_size         words to capture (clamped to DEPTH)
//   cfg_stall_period    back-pressure period (0 = none)
//   cfg_stop_on_token   a token word ends the capture
//   rd_addr, rd_data    readback address / buffer word
//   err                 sticky protocol error
module glb_stream_sink #(
  parameter int DEPTH  = glb_sink_pkg::DEFAULT_DEPTH,
  parameter int DATA_W = glb_sink_pkg::DATA_W,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  input  logic [CNT_W-1:0]  cfg_tx_size,
  input  logic [3:0]        cfg_stall_period,
  input  logic              cfg_stop_on_token,
  input  logic [CNT_W-2:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              err
);

  import glb_sink_pkg::*;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

  sink_state_e       state_r;
  logic              flush_q_r;
  logic [CNT_W-1:0]  count_r;
  logic              done_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [CNT_W-1:0]  tx_size_s;
  logic              stall_slot_s;
  logic              ready_s;
  logic              accept_s;
  logic              last_s;
  logic              stop_s;
  logic              flush_fall_s;

  glb_sink_stall_gen u_stall (
    .clk        (clk),
    .rst        (rst),
    .en         (state_r == CAPTURE),
    .clr        (flush),
    .period     (cfg_stall_period),
    .stall_slot (stall_slot_s)
  );

  // Clamp the requested size so the write address never passes DEPTH-1
  always_comb begin
    if (cfg_tx_size > DEPTH_C) begin
      tx_size_s = DEPTH_C;
    end else begin
      tx_size_s = cfg_tx_size;
    end
  end

  // Handshake terms; ready depends only on registered state
  always_comb begin
    ready_s      = (state_r == CAPTURE) && !stall_slot_s && (count_r < tx_size_s);
    // A word offered during a flush is discarded with the old capture
    accept_s     = valid && ready_s && !flush;
    last_s       = ((count_r + ONE_C) == tx_size_s);
    stop_s       = cfg_stop_on_token && data[TOKEN_BIT];
    flush_fall_s = flush_q_r && !flush;
  end

  // Capture FSM with word counter and sticky done; flush overrides every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      flush_q_r <= 1'b0;
      count_r   <= ZERO_C;
      done_r    <= 1'b0;
    end else begin
      flush_q_r <= flush;
      if (flush) begin
        state_r <= FLUSH;
        count_r <= ZERO_C;
        done_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          FLUSH: begin
            if (flush_fall_s) begin
              if (tx_size_s == ZERO_C) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= CAPTURE;
              end
            end else begin
              state_r <= FLUSH;
            end
          end
          CAPTURE: begin
            if (accept_s) begin
              count_r <= count_r + ONE_C;
              if (last_s || stop_s) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= CAPTURE;
              end
            end else begin
              state_r <= CAPTURE;
            end
          end
          DONE: begin
            state_r <= DONE;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  // Capture buffer write port; left unreset so it can map onto a RAM
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[count_r[CNT_W-2:0]] <= data;
    end
  end

  assign rd_data = mem_r[rd_addr];
  assign ready   = ready_s;
  assign done    = done_r;
  assign count   = count_r;

`ifdef GLB_SINK_PROTO_CHECK_EN
  logic              pend_r;
  logic [DATA_W-1:0] pend_data_r;
  logic              err_r;

  // A word offered while stalled must stay valid and unchanged until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r      <= 1'b0;
      pend_data_r <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      pend_r      <= valid && !ready_s && (state_r == CAPTURE) && !flush;
      pend_data_r <= data;
      if (flush) begin
        err_r <= 1'b0;
      end else if ((state_r == CAPTURE) && pend_r && (!valid || (data != pend_data_r))) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_glb_stream_sink.sv
// tb_glb_stream_sink
//   Randomized scoreboard bench for glb_stream_sink. A driver configures a
//   capture, flushes, and streams words; the words the sink should keep are
//   queued up front from the capture rules. A negedge monitor predicts ready,
//   done and count from the pattern rules and pops/compares each accepted
//   word; buffer readback is checked against a bench memory image.
module tb_glb_stream_sink;

  localparam int DEPTH = 1024;
  localparam int DW    = 17;
  localparam int CW    = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] data = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic          done;
  logic [CW-1:0] count;
  logic [CW-1:0] cfg_tx_size = '0;
  logic [3:0]    cfg_stall_period = 4'd0;
  logic          cfg_stop_on_token = 1'b0;
  logic [CW-2:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          err;

  always #5 clk = ~clk;

  glb_stream_sink dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .data              (data),
    .valid             (valid),
    .ready             (ready),
    .done              (done),
    .count             (count),
    .cfg_tx_size       (cfg_tx_size),
    .cfg_stall_period  (cfg_stall_period),
    .cfg_stop_on_token (cfg_stop_on_token),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .err               (err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] words[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_model [DEPTH];
  bit            mem_known [DEPTH];
  bit            m_active = 1'b0;
  bit            m_done   = 1'b0;
  bit            m_stop   = 1'b0;
  int            m_k = 0, m_acc = 0, m_tx = 0, m_period = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: cycle-by-cycle prediction of the handshake and scoreboard pop
  always @(negedge clk) begin
    logic [DW-1:0] w;
    bit            er;
    if (m_active) begin
      m_k++;
      chk("done", done, m_done);
      chk("count", count, m_acc);
      er = !m_done && (m_acc < m_tx) && ((m_period == 0) || ((m_k % (m_period + 1)) != 0));
      chk("ready", ready, er);
      chk("err", err, 1'b0);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_accept actual=accepted required=no_accept at %0t", $time);
        end else begin
          w = exp_q.pop_front();
          chk("data", data, w);
          mem_model[m_acc] = w;
          mem_known[m_acc] = 1'b1;
          m_acc++;
          if ((m_acc == m_tx) || (m_stop && w[16])) m_done = 1'b1;
        end
      end
    end
  end

  // Configure, build the word list and expected capture, then flush
  task automatic prep_flush(input int tx, input int period, input bit stop,
                            input int tok_at, input int tok_pct, input bit seq);
    int ctx;
    logic [DW-1:0] w;
    m_active = 1'b0;
    ctx = (tx > DEPTH) ? DEPTH : tx;
    cfg_tx_size       = tx[CW-1:0];
    cfg_stall_period  = period[3:0];
    cfg_stop_on_token = stop;
    words.delete();
    exp_q.delete();
    for (int i = 0; i < ctx + 3; i++) begin
      w = seq ? DW'(i) : DW'($urandom);
      w[16] = ($urandom_range(99) < tok_pct);
      if (i == tok_at) w = 17'h10100;
      words.push_back(w);
    end
    for (int i = 0; i < words.size(); i++) begin
      if (exp_q.size() == ctx) break;
      exp_q.push_back(words[i]);
      if (stop && words[i][16]) break;
    end
    @(posedge clk); #1 flush = 1'b1; valid = 1'b0;
    @(posedge clk); #1 flush = 1'b0;
    @(posedge clk); #1;
    m_tx = ctx; m_period = period; m_stop = stop;
    m_acc = 0; m_k = 0; m_done = (ctx == 0); m_active = 1'b1;
  endtask

  // Offer words in order (holding each until taken) until done or limit
  task automatic stream(input int limit, input int vpct);
    int idx, cyc, budget;
    bit hs;
    idx = 0; cyc = 0;
    budget = (m_tx + 4) * (m_period + 2) * 4 + 40;
    while (!m_done && (m_acc < limit) && (cyc < budget)) begin
      if (!valid && ($urandom_range(99) < vpct)) begin
        valid = 1'b1;
        data  = words[idx];
      end
      @(negedge clk);
      hs = valid && ready;
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        valid = 1'b0;
      end
      cyc++;
    end
    if (cyc >= budget) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout actual=%0d_accepts required=%0d_accepts", m_acc, m_tx);
    end
  endtask

  // Hold a word after completion (must be ignored), then check readback
  task automatic finish_run();
    int last;
    valid = 1'b1;
    data  = words[m_acc];
    repeat (3) @(posedge clk);
    #1 valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 m_active = 1'b0;
    chk("exp_left", exp_q.size(), 0);
    chk("final_done", done, 1'b1);
    last = (m_acc < DEPTH) ? m_acc : DEPTH - 1;
    for (int a = 0; a <= last; a++) begin
      if (mem_known[a]) begin
        rd_addr = a[CW-2:0];
        #1 chk($sformatf("rd_data[%0d]", a), rd_data, mem_model[a]);
      end
    end
  endtask

  task automatic run(input int tx, input int period, input bit stop,
                     input int tok_at, input int tok_pct, input int vpct, input bit seq);
    prep_flush(tx, period, stop, tok_at, tok_pct, seq);
    stream(DEPTH + 1, vpct);
    finish_run();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2;
    chk("rst_ready", ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_ready", ready, 1'b0);

    // Directed: plain 8 words, stall period 2, stop token, zero size
    run(8, 0, 1'b0, -1, 0, 100, 1'b1);
    run(6, 2, 1'b0, -1, 0, 100, 1'b0);
    run(16, 0, 1'b1, 3, 0, 100, 1'b0);
    chk("token_count", count, 4);
    run(0, 0, 1'b0, -1, 0, 100, 1'b0);
    chk("zero_count", count, 0);

    // Reset in the middle of a capture, then restart at address 0
    prep_flush(8, 0, 1'b0, -1, 0, 1'b0);
    stream(3, 100);
    valid = 1'b1;
    data  = words[3];
    #2 rst = 1'b1;
    m_active = 1'b0;
    #1;
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_count", count, 0);
    chk("midrst_err", err, 1'b0);
    @(posedge clk); #1 rst = 1'b0; valid = 1'b0;
    run(4, 1, 1'b0, -1, 0, 100, 1'b0);

    // Randomized captures
    for (int t = 0; t < 10; t++) begin
      run($urandom_range(40), $urandom_range(15), 1'($urandom_range(1)), -1, 10,
          $urandom_range(100, 50), 1'b0);
    end

    // Oversized request clamps to the buffer depth
    run(2000, 0, 1'b0, -1, 0, 100, 1'b0);
    chk("clamp_count", count, DEPTH);

`ifdef GLB_SINK_PROTO_CHECK_EN
    // Source changes its word while stalled
    begin
      int cyc;
      prep_flush(4, 1, 1'b0, -1, 0, 1'b0);
      m_active = 1'b0;
      valid = 1'b1;
      data  = 17'h00aaa;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (ready && (cyc < 20));
      @(posedge clk); #1 data = 17'h00555;
      @(posedge clk); #1;
      chk("proto_err", err, 1'b1);
      valid = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("proto_err_clear", err, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
